// File: rtl/alu_bist.sv
// Built-in self-test for the 16-bit alu: drives directed and LFSR operand
// pairs through all six alu commands, checks each response against an
// internal reference and reports pass/fail with the first failing vector.
module alu_bist #(
  parameter int          N_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [15:0] fail_op1,
  output logic [15:0] fail_op2,
  output logic [2:0]  fail_cmd,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [2:0]  alu_cmd,
  input  logic [15:0] alu_res,
  input  logic        alu_eq,
  input  logic        alu_ovf
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

  localparam logic [15:0] SEED_B   = LFSR_SEED ^ 16'h5555;
  localparam logic [15:0] TAPS     = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LAST_IDX = 16'(N_VECTORS - 1);
  localparam logic [2:0]  LAST_CMD = 3'd5;

  state_t      state, state_nxt;
  logic [15:0] idx;
  logic [2:0]  cmd_cnt;
  logic [15:0] lfsr_a, lfsr_b;
  logic [15:0] op_a, op_b;
  logic        last_check;

  logic [15:0] exp_res;
  logic        exp_eq, exp_ovf, check_ovf, mismatch;
  logic [15:0] sum, diff;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  assign last_check = (cmd_cnt == LAST_CMD) && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start outside IDLE (including FIN) is ignored
  always_comb begin
    // NOTE: a default assignment first keeps every path covered, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = CHECK;
      CHECK:   state_nxt = last_check ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == DRIVE) || (state == CHECK);
  end

  // Operand source: four directed corner pairs, then the two LFSRs
  always_comb begin
    op_a = lfsr_a;
    op_b = lfsr_b;
    case (idx)
      16'd0: begin op_a = 16'h7FFF; op_b = 16'h7FFF; end
      16'd1: begin op_a = 16'h8000; op_b = 16'hFFFF; end
      16'd2: begin op_a = 16'h0000; op_b = 16'h0000; end
      16'd3: begin op_a = 16'hFFFF; op_b = 16'h0001; end
      default: ;
    endcase
  end

  // Reference alu model evaluated on the registered operands
  always_comb begin
    sum       = alu_op1 + alu_op2;
    diff      = alu_op1 - alu_op2;
    exp_res   = 16'h0000;
    exp_ovf   = 1'b0;
    exp_eq    = (alu_op1 == alu_op2);
    check_ovf = (alu_cmd == 3'd0) || (alu_cmd == 3'd1);
    case (alu_cmd)
      3'd0: begin
        exp_res = sum;
        exp_ovf = (alu_op1[15] == alu_op2[15]) && (sum[15] != alu_op1[15]);
      end
      3'd1: begin
        exp_res = diff;
        exp_ovf = (alu_op1[15] != alu_op2[15]) && (diff[15] != alu_op1[15]);
      end
      3'd2:    exp_res = alu_op1 << alu_op2[3:0];
      3'd3:    exp_res = alu_op1 >> alu_op2[3:0];
      3'd4:    exp_res = {15'b0, alu_op1 > alu_op2};
      3'd5:    exp_res = {15'b0, alu_op1 == alu_op2};
      default: exp_res = 16'h0000;
    endcase
    mismatch = (alu_res != exp_res) || (alu_eq != exp_eq) ||
               (check_ovf && (alu_ovf != exp_ovf));
  end

  // Datapath: vector sequencing, alu drive, result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= 8'd0;
      fail_op1   <= 16'h0000;
      fail_op2   <= 16'h0000;
      fail_cmd   <= 3'd0;
      alu_op1    <= 16'h0000;
      alu_op2    <= 16'h0000;
      alu_cmd    <= 3'd0;
      idx        <= 16'd0;
      cmd_cnt    <= 3'd0;
      lfsr_a     <= LFSR_SEED;
      lfsr_b     <= SEED_B;
    end else begin
      // NOTE: non-blocking updates let every register see pre-edge values, so order here is irrelevant.
      case (state)
        IDLE: if (start) begin
          done       <= 1'b0;
          pass       <= 1'b0;
          fail_count <= 8'd0;
          fail_op1   <= 16'h0000;
          fail_op2   <= 16'h0000;
          fail_cmd   <= 3'd0;
          idx        <= 16'd0;
          cmd_cnt    <= 3'd0;
          lfsr_a     <= LFSR_SEED;
          lfsr_b     <= SEED_B;
        end
        DRIVE: begin
          alu_op1 <= op_a;
          alu_op2 <= op_b;
          alu_cmd <= cmd_cnt;
        end
        CHECK: begin
          if (mismatch) begin
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            // fail_count never returns to 0 once set, so it marks the first mismatch
            if (fail_count == 8'd0) begin
              fail_op1 <= alu_op1;
              fail_op2 <= alu_op2;
              fail_cmd <= alu_cmd;
            end
          end
          if (cmd_cnt == LAST_CMD) begin
            cmd_cnt <= 3'd0;
            idx     <= idx + 16'd1;
            // LFSRs advance only after an LFSR-sourced pair has been used
            if (idx >= 16'd4) begin
              lfsr_a <= lfsr_step(lfsr_a);
              lfsr_b <= lfsr_step(lfsr_b);
            end
          end else begin
            cmd_cnt <= cmd_cnt + 3'd1;
          end
        end
        FIN: begin
          done    <= 1'b1;
          pass    <= (fail_count == 8'd0);
          alu_op1 <= 16'h0000;
          alu_op2 <= 16'h0000;
          alu_cmd <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Testbench for alu_bist: a behavioural alu with selectable faults sits
// beside the DUT; expected verdicts come from replaying the vector list
// through that alu in plain arithmetic.
module tb_alu_bist;

  localparam int          N    = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  fail_count;
  logic [15:0] fail_op1, fail_op2;
  logic [2:0]  fail_cmd;
  logic [15:0] alu_op1, alu_op2;
  logic [2:0]  alu_cmd;
  logic [15:0] alu_res;
  logic        alu_eq, alu_ovf;

  int ntests = 0;
  int nfail  = 0;
  int fault_mode = 0;

  logic [15:0] va [N];
  logic [15:0] vb [N];

  typedef struct packed {
    logic [15:0] res;
    logic        eq;
    logic        ovf;
  } resp_t;

  alu_bist #(.N_VECTORS(N), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .fail_op1(fail_op1), .fail_op2(fail_op2), .fail_cmd(fail_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cmd(alu_cmd),
    .alu_res(alu_res), .alu_eq(alu_eq), .alu_ovf(alu_ovf)
  );

  always #5 clk = ~clk;

  function automatic resp_t golden(input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] c);
    resp_t r;
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r.res = 16'h0000;
    r.ovf = 1'b0;
    r.eq  = (a == b);
    case (c)
      3'd0: begin t = sa + sb; r.res = 16'(int'(a) + int'(b)); r.ovf = (t > 32767) || (t < -32768); end
      3'd1: begin t = sa - sb; r.res = 16'(int'(a) - int'(b)); r.ovf = (t > 32767) || (t < -32768); end
      3'd2: r.res = 16'(int'(a) << b[3:0]);
      3'd3: r.res = 16'(int'(a) >> b[3:0]);
      3'd4: r.res = (int'(a) > int'(b)) ? 16'd1 : 16'd0;
      3'd5: r.res = (a == b) ? 16'd1 : 16'd0;
      default: r.res = 16'h0000;
    endcase
    return r;
  endfunction

  // 0 golden, 1 RES[0] stuck-1, 2 ovF tied 0, 3 RES inverted, 4 single corrupted vector
  function automatic resp_t faulty(input int mode, input logic [15:0] a,
                                   input logic [15:0] b, input logic [2:0] c);
    resp_t r;
    r = golden(a, b, c);
    case (mode)
      1: r.res[0] = 1'b1;
      2: r.ovf = 1'b0;
      3: r.res = ~r.res;
      4: if (a == 16'h8000 && b == 16'hFFFF && c == 3'd1) r.res[0] = ~r.res[0];
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    resp_t r;
    r = faulty(fault_mode, alu_op1, alu_op2, alu_cmd);
    alu_res = r.res;
    alu_eq  = r.eq;
    alu_ovf = r.ovf;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic build_vectors();
    logic [15:0] a, b;
    va[0] = 16'h7FFF; vb[0] = 16'h7FFF;
    va[1] = 16'h8000; vb[1] = 16'hFFFF;
    va[2] = 16'h0000; vb[2] = 16'h0000;
    va[3] = 16'hFFFF; vb[3] = 16'h0001;
    a = SEED;
    b = SEED ^ 16'h5555;
    for (int i = 4; i < N; i++) begin
      va[i] = a; vb[i] = b;
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
  endtask

  task automatic predict(input int mode, output int cnt, output logic [15:0] f1,
                         output logic [15:0] f2, output logic [2:0] fc);
    resp_t g, f;
    logic bad;
    cnt = 0; f1 = 16'h0; f2 = 16'h0; fc = 3'd0;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < 6; c++) begin
        g = golden(va[i], vb[i], 3'(c));
        f = faulty(mode, va[i], vb[i], 3'(c));
        bad = (g.res != f.res) || (g.eq != f.eq) || (c < 2 && g.ovf != f.ovf);
        if (bad) begin
          if (cnt == 0) begin f1 = va[i]; f2 = vb[i]; fc = 3'(c); end
          if (cnt < 255) cnt++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'd0);
    check({tag, " fail_count"}, 32'(fail_count), 32'd0);
    check({tag, " fail_vec"}, {fail_op1, fail_op2}, 32'd0);
    check({tag, " fail_cmd"}, 32'(fail_cmd), 32'd0);
    check({tag, " alu_ops"}, {alu_op1, alu_op2}, 32'd0);
    check({tag, " alu_cmd"}, 32'(alu_cmd), 32'd0);
  endtask

  // One full run: start pulse in cycle 0, optional second start at cycle
  // repulse_at, then the verdict compared with the replayed expectation.
  task automatic run_and_check(input string tag, input int mode, input int repulse_at,
                               input bit check_bus);
    int cnt, c, busy_cnt, bus_err, k;
    logic [15:0] e1, e2;
    logic [2:0]  ec;
    fault_mode = mode;
    predict(mode, cnt, e1, e2, ec);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 1; busy_cnt = 0; bus_err = 0;
    while (!done && c < 12 * N + 20) begin
      if (busy) busy_cnt++;
      if (check_bus && busy && (c % 2 == 0)) begin
        k = c / 2 - 1;
        if (k < 6 * N) begin
          if (alu_op1 !== va[k / 6] || alu_op2 !== vb[k / 6] || alu_cmd !== 3'(k % 6))
            bus_err++;
        end
      end
      start = (c == repulse_at);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " done_cycle"}, 32'(c), 32'(12 * N + 2));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(12 * N));
    check({tag, " pass"}, 32'(pass), 32'(cnt == 0));
    check({tag, " fail_count"}, 32'(fail_count), 32'(cnt));
    check({tag, " fail_op1"}, 32'(fail_op1), 32'(e1));
    check({tag, " fail_op2"}, 32'(fail_op2), 32'(e2));
    check({tag, " fail_cmd"}, 32'(fail_cmd), 32'(ec));
    check({tag, " alu_idle"}, {alu_op1, alu_op2}, 32'd0);
    if (check_bus) check({tag, " bus_sequence_errors"}, 32'(bus_err), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " stays_idle"}, {31'd0, busy}, 32'd0);
    check({tag, " done_held"}, 32'(done), 32'd1);
  endtask

  initial begin
    int done_seen;
    build_vectors();
    #2 rst_n = 1'b0;
    #20;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_and_check("golden", 0, 0, 1'b1);
    run_and_check("res0_stuck", 1, 0, 1'b0);
    run_and_check("ovf_tied0", 2, 0, 1'b0);
    run_and_check("res_inverted", 3, 0, 1'b0);
    run_and_check("sub_8000_ffff", 4, 0, 1'b0);
    run_and_check("restart_busy", 0, 50, 1'b0);
    run_and_check("restart_fin", 0, 12 * N + 1, 1'b0);

    // Abort mid-run with failures already counted
    fault_mode = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    check("midrun fail_count_nonzero", 32'(fail_count != 8'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    check_all_zero("midrun_reset_hold");
    rst_n = 1'b1;
    fault_mode = 0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("after_abort no_done_no_busy", 32'(done_seen), 32'd0);
    run_and_check("after_abort", 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
